// File: rtl/srt4_div_arbiter.sv
// Round-robin arbiter sharing one SRT4 radix-4 divider among NREQ requesters.
// A zero divisor is answered locally without touching the divider. A watchdog
// aborts a divider that never raises div_end.
module srt4_div_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    div_begin,
  output logic [WIDTH-1:0]        div_a,
  output logic [WIDTH-1:0]        div_b,
  input  logic                    div_end,
  input  logic [WIDTH-1:0]        div_q,
  input  logic [WIDTH-1:0]        div_r,
  output logic                    div_abort,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         resp_valid,
  output logic [WIDTH-1:0]        resp_q,
  output logic [WIDTH-1:0]        resp_r,
  output logic                    resp_err,
  output logic                    busy
);

  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]  div_a_q, div_a_d;
  logic [WIDTH-1:0]  div_b_q, div_b_d;
  logic [WIDTH-1:0]  res_q_q, res_q_d;
  logic [WIDTH-1:0]  res_r_q, res_r_d;
  logic              res_err_q, res_err_d;

  logic              found;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     scan_idx;
  logic [WIDTH-1:0]  win_a;
  logic [WIDTH-1:0]  win_b;

  // Round-robin scan: first asserted request starting at rr_ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = PW'((32'(rr_ptr_q) + k) % 32'(NREQ));
      if (!found && req[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  // Operand slices of the current scan winner.
  always_comb begin
    win_a = req_a[win_idx*WIDTH +: WIDTH];
    win_b = req_b[win_idx*WIDTH +: WIDTH];
  end

  // Next-state, datapath captures and pulse outputs.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    win_d      = win_q;
    timer_d    = timer_q;
    grant_d    = grant_q;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    res_q_d    = res_q_q;
    res_r_d    = res_r_q;
    res_err_d  = res_err_q;
    div_begin  = 1'b0;
    div_abort  = 1'b0;
    resp_valid = '0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d            = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          if (win_b == '0) begin
            res_q_d   = '1;
            res_r_d   = win_a;
            res_err_d = 1'b1;
            state_d   = S_RESP;
          end else begin
            div_a_d = win_a;
            div_b_d = win_b;
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        div_begin = 1'b1;
        timer_d   = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // div_end wins over an expiring watchdog in the same cycle.
        if (div_end) begin
          res_q_d   = div_q;
          res_r_d   = div_r;
          res_err_d = 1'b0;
          state_d   = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          div_abort = 1'b1;
          res_q_d   = '0;
          res_r_d   = '0;
          res_err_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        resp_valid = grant_q;
        grant_d    = '0;
        rr_ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      win_q     <= '0;
      timer_q   <= '0;
      grant_q   <= '0;
      div_a_q   <= '0;
      div_b_q   <= '0;
      res_q_q   <= '0;
      res_r_q   <= '0;
      res_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_q     <= win_d;
      timer_q   <= timer_d;
      grant_q   <= grant_d;
      div_a_q   <= div_a_d;
      div_b_q   <= div_b_d;
      res_q_q   <= res_q_d;
      res_r_q   <= res_r_d;
      res_err_q <= res_err_d;
    end
  end

  assign div_a    = div_a_q;
  assign div_b    = div_b_q;
  assign grant    = grant_q;
  assign resp_q   = res_q_q;
  assign resp_r   = res_r_q;
  assign resp_err = res_err_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_srt4_div_arbiter.sv
// Bench for srt4_div_arbiter: behavioural divider with programmable latency,
// round-robin and arithmetic reference model, randomized request patterns.
module tb_srt4_div_arbiter;
  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rst_b;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic                  div_begin, div_end, div_abort, resp_err, busy;
  logic [WIDTH-1:0]      div_a, div_b, div_q, div_r, resp_q, resp_r;
  logic [NREQ-1:0]       grant, resp_valid;

  srt4_div_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .req_a(req_a), .req_b(req_b),
    .div_begin(div_begin), .div_a(div_a), .div_b(div_b), .div_end(div_end),
    .div_q(div_q), .div_r(div_r), .div_abort(div_abort), .grant(grant),
    .resp_valid(resp_valid), .resp_q(resp_q), .resp_r(resp_r),
    .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural divider: div_end appears dm_lat cycles into the wait phase.
  int               dm_lat = 0;
  int               dm_cnt = 0;
  logic             dm_busy = 1'b0, dm_end = 1'b0, spur = 1'b0;
  logic [WIDTH-1:0] dm_a = '0, dm_b = '0;
  assign div_end = dm_end | spur;

  always @(posedge clk) begin
    if (rst_b) begin
      dm_busy <= 1'b0;
      dm_end  <= 1'b0;
      div_q   <= '0;
      div_r   <= '0;
    end else begin
      dm_end <= 1'b0;
      if (div_begin) begin
        dm_a <= div_a;
        dm_b <= div_b;
        if (dm_lat == 0) begin
          dm_end <= 1'b1;
          div_q  <= div_a / div_b;
          div_r  <= div_a % div_b;
        end else begin
          dm_busy <= 1'b1;
          dm_cnt  <= dm_lat - 1;
        end
      end else if (div_abort) begin
        dm_busy <= 1'b0;
      end else if (dm_busy) begin
        if (dm_cnt == 0) begin
          dm_end  <= 1'b1;
          div_q   <= dm_a / dm_b;
          div_r   <= dm_a % dm_b;
          dm_busy <= 1'b0;
        end else begin
          dm_cnt <= dm_cnt - 1;
        end
      end
    end
  end

  int n_begin = 0, n_abort = 0, n_resp = 0;
  always @(posedge clk) begin
    if (div_begin) n_begin <= n_begin + 1;
    if (div_abort) n_abort <= n_abort + 1;
    if (resp_valid != '0) n_resp <= n_resp + 1;
  end

  int checks = 0, errors = 0, rr_m = 0;
  int op_a[NREQ], op_b[NREQ];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    op_a[i] = a;
    op_b[i] = b;
    req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  function automatic int pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++)
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [2*WIDTH:0] model_res(input int a, input int b);
    if (b == 0) return {{WIDTH{1'b1}}, WIDTH'(a), 1'b1};
    return {WIDTH'(a / b), WIDTH'(a % b), 1'b0};
  endfunction

  task automatic wait_resp(output bit ok, output int n, output logic [NREQ-1:0] rv,
                           output logic [NREQ-1:0] gr, output logic [2*WIDTH:0] res);
    ok = 0; n = 0; rv = '0; gr = '0; res = '0;
    for (int i = 0; i < 200; i++) begin
      step();
      n++;
      if (resp_valid != '0) begin
        ok = 1; rv = resp_valid; gr = grant; res = {resp_q, resp_r, resp_err};
        break;
      end
    end
  endtask

  bit               ok;
  int               n, w, nb, na, nr;
  logic [NREQ-1:0]  rv, gr;
  logic [2*WIDTH:0] res, exp_res;

  task automatic test_reset();
    rst_b = 1'b1; req = '0; req_a = '0; req_b = '0; spur = 1'b0; dm_lat = 0;
    repeat (3) step();
    checks++;
    if ({busy, grant, resp_valid, div_begin, div_abort} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0", {busy, grant, resp_valid, div_begin, div_abort});
    end
    checks++;
    if ({div_a, div_b, resp_q, resp_r, resp_err} !== '0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {div_a, div_b, resp_q, resp_r, resp_err});
    end
    rst_b = 1'b0; rr_m = 0;
    step();
    checks++;
    if ({busy, grant} !== '0) begin
      errors++; $display("FAIL idle_after_reset: got %b want 0", {busy, grant});
    end
  endtask

  task automatic test_single();
    dm_lat = 3; set_op(0, 100, 7); nb = n_begin; req = 4'b0001;
    step();
    checks++;
    if ({div_begin, grant} !== {1'b1, 4'b0001}) begin
      errors++; $display("FAIL t1_launch: got %b want 10001", {div_begin, grant});
    end
    checks++;
    if ({div_a, div_b} !== {8'd100, 8'd7}) begin
      errors++; $display("FAIL t1_operands: got %0d/%0d want 100/7", div_a, div_b);
    end
    wait_resp(ok, n, rv, gr, res); req = '0;
    checks++;
    if (!ok || n != 2 + 3) begin
      errors++; $display("FAIL t1_latency: got ok=%0d n=%0d want n=5", ok, n);
    end
    checks++;
    if ({rv, gr, res} !== {4'b0001, 4'b0001, 8'd14, 8'd2, 1'b0}) begin
      errors++; $display("FAIL t1_result: got %h want %h", {rv, gr, res}, {4'b0001, 4'b0001, 8'd14, 8'd2, 1'b0});
    end
    rr_m = 1;
    step();
    checks++;
    if ({busy, grant, resp_valid} !== '0 || resp_q !== 8'd14) begin
      errors++; $display("FAIL t1_after: got busy/grant/rv=%b q=%0d want 0 q=14", {busy, grant, resp_valid}, resp_q);
    end
    checks++;
    if (n_begin - nb != 1) begin
      errors++; $display("FAIL t1_begins: got %0d want 1", n_begin - nb);
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < NREQ; i++) set_op(i, $urandom_range(0, 255), $urandom_range(1, 255));
    nb = n_begin; req = '1;
    for (int j = 0; j < 5; j++) begin
      dm_lat = $urandom_range(0, 3);
      wait_resp(ok, n, rv, gr, res);
      w = pick(req, rr_m);
      if (j == 4) req = '0;
      exp_res = model_res(op_a[w], op_b[w]);
      checks++;
      if (!ok || rv !== (NREQ'(1) << w) || gr !== rv) begin
        errors++; $display("FAIL rr_grant[%0d]: got rv=%b gr=%b want %b", j, rv, gr, NREQ'(1) << w);
      end
      checks++;
      if (res !== exp_res) begin
        errors++; $display("FAIL rr_result[%0d]: got %h want %h", j, res, exp_res);
      end
      rr_m = (w + 1) % NREQ;
    end
    step();
    checks++;
    if (n_begin - nb != 5) begin
      errors++; $display("FAIL rr_begins: got %0d want 5", n_begin - nb);
    end
  endtask

  task automatic test_zero();
    set_op(2, 55, 0); nb = n_begin; req = 4'b0100;
    wait_resp(ok, n, rv, gr, res); req = '0;
    checks++;
    if (!ok || n != 1 || rv !== 4'b0100) begin
      errors++; $display("FAIL t3_timing: got ok=%0d n=%0d rv=%b want n=1 rv=0100", ok, n, rv);
    end
    checks++;
    if (res !== {8'hFF, 8'd55, 1'b1}) begin
      errors++; $display("FAIL t3_result: got %h want %h", res, {8'hFF, 8'd55, 1'b1});
    end
    rr_m = 3;
    step();
    checks++;
    if (n_begin != nb) begin
      errors++; $display("FAIL t3_no_begin: got %0d begins want 0", n_begin - nb);
    end
  endtask

  task automatic test_timeout();
    dm_lat = 1000; set_op(1, 9, 3); na = n_abort; req = 4'b0010;
    wait_resp(ok, n, rv, gr, res); req = '0;
    checks++;
    if (!ok || n != 3 + TIMEOUT - 1 || rv !== 4'b0010) begin
      errors++; $display("FAIL t4_timing: got ok=%0d n=%0d rv=%b want n=%0d rv=0010", ok, n, rv, 2 + TIMEOUT);
    end
    checks++;
    if (res !== {8'd0, 8'd0, 1'b1} || n_abort - na != 1) begin
      errors++; $display("FAIL t4_result: got %h aborts=%0d want 00001 aborts=1", res, n_abort - na);
    end
    rr_m = 2;
    step();
    dm_lat = 2; req = 4'b0010;
    wait_resp(ok, n, rv, gr, res); req = '0;
    checks++;
    if (!ok || n != 5 || res !== {8'd3, 8'd0, 1'b0} || n_abort - na != 1) begin
      errors++; $display("FAIL t4_next: got n=%0d res=%h aborts=%0d want n=5 res=%h aborts=1", n, res, n_abort - na, {8'd3, 8'd0, 1'b0});
    end
    step();
  endtask

  task automatic test_race();
    w = $urandom_range(0, NREQ - 1);
    set_op(w, $urandom_range(0, 255), $urandom_range(1, 255));
    exp_res = model_res(op_a[w], op_b[w]);
    dm_lat = TIMEOUT - 1; na = n_abort; req = NREQ'(1) << w;
    wait_resp(ok, n, rv, gr, res); req = '0;
    checks++;
    if (!ok || n != 3 + TIMEOUT - 1 || res !== exp_res || n_abort != na) begin
      errors++; $display("FAIL t5_race: got n=%0d res=%h aborts=%0d want n=%0d res=%h aborts=0", n, res, n_abort - na, 2 + TIMEOUT, exp_res);
    end
    rr_m = (w + 1) % NREQ;
    step();
  endtask

  task automatic test_spurious_end();
    bit bad;
    bad = 0; spur = 1'b1;
    repeat (3) begin
      step();
      if (busy || resp_valid != '0 || div_abort) bad = 1;
    end
    spur = 1'b0;
    checks++;
    if (bad) begin
      errors++; $display("FAIL spurious_end: got reaction to idle div_end want none");
    end
  endtask

  task automatic test_drop();
    set_op(3, $urandom_range(0, 255), $urandom_range(1, 255));
    exp_res = model_res(op_a[3], op_b[3]);
    dm_lat = 2; req = 4'b1000;
    step();
    req = '0;
    req_a[3*WIDTH +: WIDTH] = ~req_a[3*WIDTH +: WIDTH];
    req_b[3*WIDTH +: WIDTH] = '0;
    wait_resp(ok, n, rv, gr, res);
    checks++;
    if (!ok || n != 4 || rv !== 4'b1000 || res !== exp_res) begin
      errors++; $display("FAIL drop_hold: got n=%0d rv=%b res=%h want n=4 rv=1000 res=%h", n, rv, res, exp_res);
    end
    rr_m = 0;
    step();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] pending;
    for (int rnd = 0; rnd < 25; rnd++) begin
      pending = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++)
        set_op(i, $urandom_range(0, 255), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255));
      req = pending;
      while (pending != '0) begin
        dm_lat = $urandom_range(0, 6);
        wait_resp(ok, n, rv, gr, res);
        w = pick(pending, rr_m);
        pending[w] = 1'b0;
        req = pending;
        exp_res = model_res(op_a[w], op_b[w]);
        checks++;
        if (!ok || rv !== (NREQ'(1) << w) || gr !== rv) begin
          errors++; $display("FAIL rand_grant[%0d]: got rv=%b gr=%b want %b", rnd, rv, gr, NREQ'(1) << w);
        end
        checks++;
        if (res !== exp_res) begin
          errors++; $display("FAIL rand_result[%0d]: got %h want %h", rnd, res, exp_res);
        end
        rr_m = (w + 1) % NREQ;
        if (!ok) begin
          pending = '0; req = '0;
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    dm_lat = 0; set_op(1, 20, 6); req = 4'b0010;
    wait_resp(ok, n, rv, gr, res); req = '0;
    step();
    set_op(2, 200, 9); dm_lat = 20; req = 4'b0100;
    repeat (4) step();
    checks++;
    if (busy !== 1'b1 || grant !== 4'b0100) begin
      errors++; $display("FAIL t6_inflight: got busy=%b grant=%b want 1/0100", busy, grant);
    end
    nr = n_resp; na = n_abort;
    rst_b = 1'b1; set_op(1, 77, 5); set_op(3, 90, 4); req = 4'b1010;
    step();
    checks++;
    if ({busy, grant, resp_valid, div_begin, div_abort, div_a, div_b, resp_q, resp_r, resp_err} !== '0) begin
      errors++; $display("FAIL t6_reset_outputs: got %h want 0", {busy, grant, resp_valid, div_begin, div_abort, div_a, div_b, resp_q, resp_r, resp_err});
    end
    rst_b = 1'b0; rr_m = 0;
    wait_resp(ok, n, rv, gr, res); req = 4'b1000;
    checks++;
    if (!ok || rv !== 4'b0010 || res !== model_res(77, 5)) begin
      errors++; $display("FAIL t6_first: got rv=%b res=%h want 0010 %h", rv, res, model_res(77, 5));
    end
    wait_resp(ok, n, rv, gr, res); req = '0;
    checks++;
    if (!ok || rv !== 4'b1000 || res !== model_res(90, 4)) begin
      errors++; $display("FAIL t6_second: got rv=%b res=%h want 1000 %h", rv, res, model_res(90, 4));
    end
    rr_m = 0;
    step();
    checks++;
    if (n_resp - nr != 2 || n_abort != na) begin
      errors++; $display("FAIL t6_no_stray: got resps=%0d aborts=%0d want 2/0", n_resp - nr, n_abort - na);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero();
    test_timeout();
    test_race();
    test_spurious_end();
    test_drop();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
